// File: rtl/mv_stream_reader.sv
// mv_stream_reader: captures a full frame of per-block motion vectors in one
// strobe and replays it block by block in raster order over a valid/ready
// stream, counting nonzero vectors for the frame summary.
module mv_stream_reader #(
  parameter int H         = 320,
  parameter int V         = 240,
  parameter int blocksize = 8,
  parameter int N         = 12,
  localparam int BH = H / blocksize,
  localparam int BV = V / blocksize,
  localparam int NB = BH * BV,
  localparam int XW = $clog2(BH),
  localparam int YW = $clog2(BV),
  localparam int CW = $clog2(NB + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vec_valid,
  input  logic [N*NB-1:0] vector_x,
  input  logic [N*NB-1:0] vector_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XW-1:0]   out_bx,
  output logic [YW-1:0]   out_by,
  output logic [N-1:0]    out_vx,
  output logic [N-1:0]    out_vy,
  output logic            out_last,
  output logic            busy,
  output logic            frame_done,
  output logic [CW-1:0]   nz_count,
  output logic            drop
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]      state;
  logic [N*NB-1:0] frame_x, frame_y;
  logic [CW-1:0]   idx;
  logic [XW-1:0]   bx_q;
  logic [YW-1:0]   by_q;
  logic [CW-1:0]   nz_run;
  logic            capture, accept, nz_inc;

  assign capture    = (state == S_IDLE) && vec_valid;
  assign out_valid  = (state == S_STREAM);
  assign accept     = out_valid && out_ready;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign out_bx     = bx_q;
  assign out_by     = by_q;
  // Vector outputs are gated so the unreset frame store never leaks out
  // while idle or in reset.
  assign out_vx     = out_valid ? frame_x[idx*N +: N] : '0;
  assign out_vy     = out_valid ? frame_y[idx*N +: N] : '0;
  assign out_last   = out_valid && (idx == CW'(NB - 1));
  assign nz_inc     = (|out_vx) || (|out_vy);

  // Frame store: loaded only on an idle capture, holds across the stream.
  always_ff @(posedge clk) begin
    if (capture) begin
      frame_x <= vector_x;
      frame_y <= vector_y;
    end
  end

  // Sequencer: capture, raster walk on accept, one-cycle done, back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      nz_run   <= '0;
      nz_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (vec_valid) begin
          state  <= S_STREAM;
          idx    <= '0;
          bx_q   <= '0;
          by_q   <= '0;
          nz_run <= '0;
        end
        S_STREAM: if (accept) begin
          nz_run <= nz_run + CW'(nz_inc);
          if (out_last) begin
            // Rewind coordinates so idle outputs read (0,0).
            state    <= S_DONE;
            nz_count <= nz_run + CW'(nz_inc);
            idx      <= '0;
            bx_q     <= '0;
            by_q     <= '0;
          end else begin
            idx <= idx + 1'b1;
            if (bx_q == XW'(BH - 1)) begin
              bx_q <= '0;
              by_q <= by_q + 1'b1;
            end else begin
              bx_q <= bx_q + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Overrun flag: sticky on any strobe while busy, cleared by the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    drop <= 1'b0;
    else if (capture)            drop <= 1'b0;
    else if (vec_valid && busy)  drop <= 1'b1;
  end

endmodule

// File: tb/tb_mv_stream_reader.sv
// Randomized bench for mv_stream_reader: a per-block reference frame is kept
// as plain arrays and the expected beat sequence is derived from block index.
module tb_mv_stream_reader;
  localparam int NB = 1200;
  localparam int N  = 12;
  localparam int TMO = 20000;

  logic              clk = 1'b0;
  logic              rst;
  logic              vec_valid;
  logic [N*NB-1:0]   vector_x, vector_y;
  logic              out_valid, out_ready;
  logic [5:0]        out_bx;
  logic [4:0]        out_by;
  logic [N-1:0]      out_vx, out_vy;
  logic              out_last, busy, frame_done, drop;
  logic [10:0]       nz_count;

  logic [N-1:0] ex [NB];
  logic [N-1:0] ey [NB];
  int tests = 0;
  int fails = 0;

  mv_stream_reader dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid),
    .vector_x(vector_x), .vector_y(vector_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bx(out_bx), .out_by(out_by), .out_vx(out_vx), .out_vy(out_vy),
    .out_last(out_last), .busy(busy), .frame_done(frame_done),
    .nz_count(nz_count), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic pack();
    for (int k = 0; k < NB; k++) begin
      vector_x[k*N +: N] = ex[k];
      vector_y[k*N +: N] = ey[k];
    end
  endtask

  function automatic int count_nz();
    int c = 0;
    for (int k = 0; k < NB; k++) if (ex[k] != 0 || ey[k] != 0) c++;
    return c;
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < NB; k++) begin
      ex[k] = N'(k % 7);
      ey[k] = '0;
    end
  endtask

  // Streams the current reference frame. mode: 0 ready=1, 1 toggle 1/0,
  // 2 random. ovr_at: beat at which a second strobe arrives (-1 none).
  // pulse_done: strobe during the done cycle, which must not be captured.
  task automatic test_stream(input int mode, input int ovr_at,
                             input bit pulse_done, input string tag);
    int k = 0, cyc = 0;
    int enz;
    bit exp_drop;
    logic [5:0] eb;
    logic [4:0] eby;
    enz = count_nz();
    exp_drop = (ovr_at >= 0);
    pack();
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || drop !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s capture: valid=%b drop=%b busy=%b want 1 0 1", tag, out_valid, drop, busy);
    end
    while (k < NB && cyc < TMO) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (k == ovr_at && ovr_at >= 0) begin
        vec_valid = 1'b1;
        vector_x  = ~vector_x;
        vector_y  = ~vector_y;
        ovr_at    = -1;
      end
      eb  = 6'(k % 40);
      eby = 5'(k / 40);
      tests++;
      if (out_valid !== 1'b1 || out_bx !== eb || out_by !== eby ||
          out_vx !== ex[k] || out_vy !== ey[k] || out_last !== (k == NB-1) ||
          busy !== 1'b1 || frame_done !== 1'b0) begin
        fails++;
        $display("FAIL %s beat %0d: v=%b bx=%0d by=%0d vx=%h vy=%h last=%b fd=%b want bx=%0d by=%0d vx=%h vy=%h",
                 tag, k, out_valid, out_bx, out_by, out_vx, out_vy, out_last, frame_done,
                 eb, eby, ex[k], ey[k]);
      end
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
      vec_valid = 1'b0;
    end
    out_ready = 1'b0;
    if (cyc >= TMO) begin
      tests++; fails++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, NB);
    end
    tests++;
    if (frame_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 ||
        nz_count !== 11'(enz) || drop !== exp_drop) begin
      fails++;
      $display("FAIL %s done: fd=%b v=%b busy=%b nz=%0d drop=%b want 1 0 1 %0d %b",
               tag, frame_done, out_valid, busy, nz_count, drop, enz, exp_drop);
    end
    if (pulse_done) vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        drop !== (exp_drop || pulse_done) || nz_count !== 11'(enz)) begin
      fails++;
      $display("FAIL %s idle: fd=%b busy=%b v=%b drop=%b nz=%0d want 0 0 0 %b %0d",
               tag, frame_done, busy, out_valid, drop, nz_count, exp_drop || pulse_done, enz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; vec_valid = 1'b0; out_ready = 1'b0;
    vector_x = '0; vector_y = '0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_bx !== 6'd0 || out_by !== 5'd0 || out_vx !== 12'd0 ||
        out_vy !== 12'd0 || out_last !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        nz_count !== 11'd0 || drop !== 1'b0) begin
      fails++;
      $display("FAIL reset: v=%b bx=%0d by=%0d vx=%h vy=%h last=%b busy=%b fd=%b nz=%0d drop=%b want all 0",
               out_valid, out_bx, out_by, out_vx, out_vy, out_last, busy, frame_done, nz_count, drop);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    pack();
    vec_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (300) @(negedge clk);
    tests++;
    if (out_bx !== 6'd20 || out_by !== 5'd7) begin
      fails++;
      $display("FAIL reset_mid pre: bx=%0d by=%0d want 20 7", out_bx, out_by);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_bx !== 6'd0 || out_vx !== 12'd0 ||
        nz_count !== 11'd0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: v=%b busy=%b bx=%0d vx=%h nz=%0d fd=%b want 0s",
               out_valid, busy, out_bx, out_vx, nz_count, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid hold: fd=%b busy=%b want 0 0", frame_done, busy);
      end
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    test_stream(0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_ramp();
    fill_ramp();
    test_stream(0, -1, 1'b0, "ramp");
    tests++;
    if (nz_count !== 11'd1028) begin
      fails++;
      $display("FAIL ramp nz: got %0d want 1028", nz_count);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    test_stream(1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_negative();
    for (int k = 0; k < NB; k++) begin ex[k] = '0; ey[k] = '0; end
    ex[NB-1] = 12'hFFB;
    ey[NB-1] = 12'hFFF;
    test_stream(0, -1, 1'b0, "negative");
    tests++;
    if (nz_count !== 11'd1) begin
      fails++;
      $display("FAIL negative nz: got %0d want 1", nz_count);
    end
  endtask

  task automatic test_overrun();
    for (int k = 0; k < NB; k++) begin
      ex[k] = N'($urandom);
      ey[k] = N'($urandom);
    end
    test_stream(0, 500, 1'b1, "overrun");
    for (int k = 0; k < NB; k++) begin
      ex[k] = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
      ey[k] = '0;
    end
    test_stream(0, -1, 1'b0, "post_overrun");
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NB; k++) begin
        ex[k] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        ey[k] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      end
      test_stream(2, -1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_ramp();
    test_backpressure();
    test_negative();
    test_overrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
